matrix_add_pipe: RTL and testbench
==================================

# matrix_add_pipe

Parametrised, pipelined successor of the 8-lane 16-bit pairwise matrix adder. Adds two packed vectors of `LANES` unsigned elements lane by lane. Supports wrap or saturating arithmetic and a per-frame accumulate mode. Both sides use a valid/ready handshake with one registered output stage, so it sits directly in the streaming datapath between operand fetch and result write-back.

## Interface
Parameters:
- `LANES`, 8, number of element lanes
- `W`, 16, element width in bits (unsigned)
- `SAT`, 0, 0 = modulo-2^W wrap, 1 = saturate to 2^W-1

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  operand beat valid
- `in_ready`  out  1  block accepts beat this cycle
- `in_a`  in  LANES*W  operand A; lane i = bits [i*W +: W]
- `in_b`  in  LANES*W  operand B, same packing
- `in_last`  in  1  final beat of an accumulate frame (ignored in add mode)
- `mode`  in  1  0 = pairwise add, 1 = accumulate; sampled on first beat of a frame
- `out_valid`  out  1  result valid
- `out_ready`  in  1  downstream accepts result
- `out_data`  out  LANES*W  result, same packing
- `out_ovf`  out  LANES  per-lane overflow/saturation flag (sticky across frame)

## Operation
- Beat accepted when `in_valid && in_ready`. Result accepted when `out_valid && out_ready`.
- Lane sum s_i = acc_i + a_i + b_i, computed at W+2 bits. acc_i = 0 in add mode and on the first beat of a frame.
- Overflow for a lane: s_i > 2^W-1. With SAT=0 the lane result is s_i mod 2^W. With SAT=1 it is 2^W-1. Either way the ovf bit is set.
- Add mode: every accepted beat produces one result. `out_ovf` reflects that beat only.
- Accumulate mode: lane results are kept in the internal accumulator and ovf bits are ORed across beats. A result is emitted only on the beat with `in_last`=1. The accumulator then clears.
- A single-beat frame (first beat has `in_last`=1) is legal and behaves as add mode.
- `mode` is latched at frame start. Changes to `mode` mid-frame are ignored until after the `in_last` beat.
- FSM states:
  - IDLE: no frame open, output empty.
  - ACC: accumulate frame open. Entered from IDLE on an accepted beat with mode=1, in_last=0. Returns to IDLE on the accepted in_last beat.
  - Output-register occupancy is tracked separately by `out_valid`.
- `in_ready` = !out_valid || out_ready. This gives full throughput, with a combinational ready path to upstream.
- In ACC, beats without `in_last` update only the accumulator. They still require `in_ready`, so ordering is kept simple.

## Timing
- Latency is 1 cycle: a beat accepted at edge n makes its result valid after edge n (`out_valid` high in cycle n+1). For accumulate mode, "the beat" is the in_last beat.
- Throughput is one beat per cycle when `out_ready` is held high.
- Backpressure: while `out_valid && !out_ready`, the `out_data`/`out_ovf` hold stable and `in_ready`=0.
- Simultaneous output accept and input accept in the same cycle: the output register reloads with the new result and `out_valid` stays 1.
- Reset (asynchronous assert, synchronous-to-clk deassert is an upstream responsibility) values:
  - `out_valid`=0, `out_data`=0, `out_ovf`=0.
  - Accumulator=0, FSM=IDLE, so `in_ready`=1.
- Reset mid-frame discards the partial accumulation. No result is emitted for it.

## Structure
- Shared package `matrix_add_pkg`: mode encoding constants (MODE_ADD=0, MODE_ACC=1), FSM state enum, and a lane-slice helper function.
- One natural sub-module, `mia_lane_add`: a combinational single-lane adder with the SAT parameter. Inputs acc/a/b; outputs result and ovf. It is instantiated LANES times via generate.
- Top level holds the FSM, accumulator, and output register.

## Test plan
- Reset and add mode, LANES=8, W=16, SAT=0: lane0 a=0x0003, b=0x0004 and lane7 a=0xFFFF, b=0x0002 -> next cycle lane0=0x0007, lane7=0x0001, out_ovf=0x80.
- Same stimulus with SAT=1 -> lane7=0xFFFF, out_ovf=0x80. Other lanes are unaffected.
- Accumulate: 3 beats, all lanes a=1, b=2, in_last on beat 3 -> exactly one result, all lanes=9, out_valid only after beat 3.
- Backpressure: stream 4 add-mode beats with out_ready low for 3 cycles -> in_ready=0 during the stall, out_data is stable, no beat is lost or duplicated, and the 4 results arrive in order.
- Mid-frame `mode` toggle to 0 after beat 1 of an accumulate frame -> frame still accumulates until in_last. Assert rst_n low mid-frame -> outputs 0 immediately, and the next frame starts from acc=0.
- Wrap in accumulate, SAT=0, W=8: two beats a=0x80, b=0x00 -> result 0x00 with ovf set.

Source files
------------

// File: rtl/matrix_add_pkg.sv
// matrix_add_pkg
//   Shared definitions for the pipelined lane adder:
//   - MODE_ADD / MODE_ACC : encoding of the `mode` input
//   - state_t             : frame FSM states (IDLE = no frame open, ACC = accumulate frame open)
//   - lane_lo()           : low bit index of a lane inside a packed LANES*W vector
package matrix_add_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_ACC = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_t;

    // Lane i of a packed vector occupies bits [lane_lo(i, W) +: W].
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/mia_lane_add.sv
// mia_lane_add
//   Combinational single-lane adder: result = acc + a + b, evaluated at W+2 bits
//   so that the sum of three W-bit operands can never be lost.
//   Ports:
//     acc, a, b : W-bit unsigned operands
//     result    : W-bit lane result (wrapped, or clamped to all-ones when SAT != 0)
//     ovf       : high when the true sum exceeds 2^W-1
module mia_lane_add
    import matrix_add_pkg::*;
#(
    parameter int W   = 16,
    parameter int SAT = 0
) (
    input  logic [W-1:0] acc,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] result,
    output logic         ovf
);

    logic [W+1:0] sum_full;

    assign sum_full = {2'b00, acc} + {2'b00, a} + {2'b00, b};

    // Any bit above the element width means the lane no longer fits.
    assign ovf    = |sum_full[W+1:W];
    assign result = ((SAT != 0) && ovf) ? {W{1'b1}} : sum_full[W-1:0];

endmodule

// File: rtl/matrix_add_pipe.sv
// matrix_add_pipe
//   Lane-wise adder of two packed vectors of LANES unsigned W-bit elements with
//   wrap/saturate arithmetic, an optional per-frame accumulate mode and a single
//   registered output stage behind a valid/ready handshake on both sides.
//   Ports:
//     clk, rst_n          : clock (rising edge), asynchronous active-low reset
//     in_valid / in_ready : operand beat handshake
//     in_a, in_b          : packed operands, lane i = bits [i*W +: W]
//     in_last             : last beat of an accumulate frame
//     mode                : 0 = add, 1 = accumulate; taken on the first beat of a frame
//     out_valid/out_ready : result handshake
//     out_data            : packed result
//     out_ovf             : per-lane overflow, ORed over all beats of a frame
module matrix_add_pipe
    import matrix_add_pkg::*;
#(
    parameter int LANES = 8,
    parameter int W     = 16,
    parameter int SAT   = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LANES*W-1:0] in_a,
    input  logic [LANES*W-1:0] in_b,
    input  logic               in_last,
    input  logic               mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*W-1:0] out_data,
    output logic [LANES-1:0]   out_ovf
);

    state_t             state_reg;
    logic [LANES*W-1:0] acc_reg;
    logic [LANES-1:0]   acc_ovf_reg;
    logic               out_valid_reg;
    logic [LANES*W-1:0] out_data_reg;
    logic [LANES-1:0]   out_ovf_reg;

    logic               in_frame;
    logic               frame_acc;
    logic               fire;
    logic               emit;
    logic [LANES*W-1:0] sum_vec;
    logic [LANES-1:0]   lane_ovf;
    logic [LANES-1:0]   ovf_total;

    // An open frame forces accumulate regardless of the live mode input, which
    // is how mode gets latched without a separate register.
    assign in_frame  = (state_reg == ST_ACC);
    assign frame_acc = in_frame || (mode == MODE_ACC);

    assign in_ready  = !out_valid_reg || out_ready;
    assign fire      = in_valid && in_ready;
    assign emit      = !frame_acc || in_last;

    // Overflow stays sticky for the whole frame; outside a frame it is per beat.
    assign ovf_total = lane_ovf | (in_frame ? acc_ovf_reg : '0);

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            mia_lane_add #(
                .W   (W),
                .SAT (SAT)
            ) u_lane (
                .acc    (in_frame ? acc_reg[lane_lo(gi, W) +: W] : '0),
                .a      (in_a[lane_lo(gi, W) +: W]),
                .b      (in_b[lane_lo(gi, W) +: W]),
                .result (sum_vec[lane_lo(gi, W) +: W]),
                .ovf    (lane_ovf[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            acc_reg       <= '0;
            acc_ovf_reg   <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_ovf_reg   <= '0;
        end else begin
            if (out_valid_reg && out_ready) begin
                out_valid_reg <= 1'b0;
            end
            if (fire) begin
                if (emit) begin
                    // Overrides the drop above when a result is consumed and
                    // replaced in the same cycle.
                    out_valid_reg <= 1'b1;
                    out_data_reg  <= sum_vec;
                    out_ovf_reg   <= ovf_total;
                    acc_reg       <= '0;
                    acc_ovf_reg   <= '0;
                    state_reg     <= ST_IDLE;
                end else begin
                    acc_reg       <= sum_vec;
                    acc_ovf_reg   <= ovf_total;
                    state_reg     <= ST_ACC;
                end
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_ovf   = out_ovf_reg;

endmodule

// File: tb/tb_matrix_add_pipe.sv
// tb_matrix_add_pipe
//   Drives three instances (W=16 wrap, W=16 saturate, W=8 wrap; all 8 lanes)
//   with the same beats. A lane-value model built from plain integer arithmetic
//   queues expected results; a compare process checks every cycle.
module tb_matrix_add_pipe;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic         mode = 1'b0;
    logic         out_ready = 1'b1;
    logic [127:0] in_a16 = '0;
    logic [127:0] in_b16 = '0;
    logic [63:0]  in_a8 = '0;
    logic [63:0]  in_b8 = '0;

    logic         rdy_w16, rdy_s16, rdy_w8;
    logic         ov_w16, ov_s16, ov_w8;
    logic [127:0] dat_w16, dat_s16;
    logic [63:0]  dat_w8;
    logic [7:0]   flg_w16, flg_s16, flg_w8;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    matrix_add_pipe #(.LANES(8), .W(16), .SAT(0)) u_w16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_w16),
        .in_a(in_a16), .in_b(in_b16), .in_last(in_last), .mode(mode),
        .out_valid(ov_w16), .out_ready(out_ready), .out_data(dat_w16), .out_ovf(flg_w16));

    matrix_add_pipe #(.LANES(8), .W(16), .SAT(1)) u_s16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_s16),
        .in_a(in_a16), .in_b(in_b16), .in_last(in_last), .mode(mode),
        .out_valid(ov_s16), .out_ready(out_ready), .out_data(dat_s16), .out_ovf(flg_s16));

    matrix_add_pipe #(.LANES(8), .W(8), .SAT(0)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_w8),
        .in_a(in_a8), .in_b(in_b8), .in_last(in_last), .mode(mode),
        .out_valid(ov_w8), .out_ready(out_ready), .out_data(dat_w8), .out_ovf(flg_w8));

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    typedef struct packed {
        logic [127:0] d16w;
        logic [7:0]   o16w;
        logic [127:0] d16s;
        logic [7:0]   o16s;
        logic [63:0]  d8;
        logic [7:0]   o8;
    } exp_t;

    exp_t q[$];
    int   cur_a[8];
    int   cur_b[8];
    int   acc_cnt = 0;
    bit   frame_open = 1'b0;
    int   m16w[8], m16s[8], m8[8];
    bit [7:0] v16w, v16s, v8;

    task automatic lane_step(input int maxv, input bit sat, input int accv, input int av,
                             input int bv, output int res, output bit ov);
        int s;
        s   = accv + av + bv;
        ov  = (s > maxv);
        res = ov ? (sat ? maxv : s % (maxv + 1)) : s;
    endtask

    initial begin
        bit   exp_valid, fire, is_acc, ov;
        int   r;
        exp_t e;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                q.delete();
                frame_open = 1'b0;
            end else begin
                exp_valid = (q.size() != 0);
                fire = in_valid && (!exp_valid || out_ready);
                if (exp_valid && out_ready) void'(q.pop_front());
                if (fire) begin
                    if (!frame_open) begin
                        for (int l = 0; l < 8; l++) begin
                            m16w[l] = 0; m16s[l] = 0; m8[l] = 0;
                        end
                        v16w = '0; v16s = '0; v8 = '0;
                    end
                    is_acc = frame_open || mode;
                    for (int l = 0; l < 8; l++) begin
                        lane_step(65535, 1'b0, m16w[l], cur_a[l] & 65535, cur_b[l] & 65535, r, ov);
                        m16w[l] = r; v16w[l] = v16w[l] | ov;
                        lane_step(65535, 1'b1, m16s[l], cur_a[l] & 65535, cur_b[l] & 65535, r, ov);
                        m16s[l] = r; v16s[l] = v16s[l] | ov;
                        lane_step(255, 1'b0, m8[l], cur_a[l] & 255, cur_b[l] & 255, r, ov);
                        m8[l] = r; v8[l] = v8[l] | ov;
                    end
                    if (!is_acc || in_last) begin
                        e = '0;
                        for (int l = 0; l < 8; l++) begin
                            e.d16w[l*16 +: 16] = m16w[l][15:0];
                            e.d16s[l*16 +: 16] = m16s[l][15:0];
                            e.d8[l*8 +: 8]     = m8[l][7:0];
                        end
                        e.o16w = v16w; e.o16s = v16s; e.o8 = v8;
                        q.push_back(e);
                        frame_open = 1'b0;
                    end else begin
                        frame_open = 1'b1;
                    end
                    acc_cnt++;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        bit exp_valid, exp_ready;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                exp_valid = (q.size() != 0);
                exp_ready = !exp_valid || out_ready;
                check("out_valid_w16", 128'(ov_w16), 128'(exp_valid));
                check("out_valid_s16", 128'(ov_s16), 128'(exp_valid));
                check("out_valid_w8",  128'(ov_w8),  128'(exp_valid));
                check("in_ready_w16",  128'(rdy_w16), 128'(exp_ready));
                check("in_ready_s16",  128'(rdy_s16), 128'(exp_ready));
                check("in_ready_w8",   128'(rdy_w8),  128'(exp_ready));
                if (exp_valid) begin
                    check("data_w16", dat_w16, q[0].d16w);
                    check("ovf_w16",  128'(flg_w16), 128'(q[0].o16w));
                    check("data_s16", dat_s16, q[0].d16s);
                    check("ovf_s16",  128'(flg_s16), 128'(q[0].o16s));
                    check("data_w8",  128'(dat_w8), 128'(q[0].d8));
                    check("ovf_w8",   128'(flg_w8), 128'(q[0].o8));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_all(input int av, input int bv);
        for (int l = 0; l < 8; l++) begin
            cur_a[l] = av; cur_b[l] = bv;
        end
    endtask

    task automatic send(input bit m, input bit last);
        int start, guard;
        for (int l = 0; l < 8; l++) begin
            in_a16[l*16 +: 16] = cur_a[l][15:0];
            in_b16[l*16 +: 16] = cur_b[l][15:0];
            in_a8[l*8 +: 8]    = cur_a[l][7:0];
            in_b8[l*8 +: 8]    = cur_b[l][7:0];
        end
        mode = m; in_last = last; in_valid = 1'b1;
        start = acc_cnt; guard = 0;
        do begin
            @(posedge clk); #1;
            guard++;
        end while (acc_cnt == start && guard < 50);
        if (acc_cnt == start) begin
            n_checks++; n_errors++;
            $display("FAIL send_timeout: beat not accepted within 50 cycles at %0t", $time);
        end
        $display("beat accepted: mode=%0d last=%0d a0=%h b0=%h", m, last, cur_a[0], cur_b[0]);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        bit done;
        int g;
        set_all(0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 128'(ov_w16), 128'(0));
        check("rst_out_data",  dat_w16, 128'(0));
        check("rst_in_ready",  128'(rdy_w16), 128'(1));
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Add mode: lane0 3+4, lane7 0xFFFF+2
        set_all(0, 0);
        cur_a[0] = 16'h0003; cur_b[0] = 16'h0004;
        cur_a[7] = 16'hFFFF; cur_b[7] = 16'h0002;
        send(1'b0, 1'b0);
        check("add_w16_lane0", 128'(dat_w16[15:0]), 128'(16'h0007));
        check("add_w16_lane7", 128'(dat_w16[127:112]), 128'(16'h0001));
        check("add_w16_ovf",   128'(flg_w16), 128'(8'h80));
        check("add_s16_lane7", 128'(dat_s16[127:112]), 128'(16'hFFFF));
        check("add_s16_lane0", 128'(dat_s16[15:0]), 128'(16'h0007));
        check("add_s16_ovf",   128'(flg_s16), 128'(8'h80));
        check("add_w8_lane7",  128'(dat_w8[63:56]), 128'(8'h01));
        idle(1);

        // Accumulate 3 beats of 1+2
        set_all(1, 2);
        send(1'b1, 1'b0);
        check("acc_beat1_no_out", 128'(ov_w16), 128'(0));
        send(1'b1, 1'b0);
        check("acc_beat2_no_out", 128'(ov_w16), 128'(0));
        send(1'b1, 1'b1);
        check("acc_result", dat_w16, {8{16'h0009}});
        check("acc_ovf",    128'(flg_w16), 128'(0));
        idle(1);

        // Backpressure: 4 beats, out_ready low 3 cycles
        done = 1'b0;
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    for (int l = 0; l < 8; l++) begin
                        cur_a[l] = l * 256 + k; cur_b[l] = k * 3;
                    end
                    send(1'b0, 1'b0);
                end
                in_valid = 1'b0;
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        idle(2);

        // Mode dropped to 0 mid-frame: frame keeps accumulating
        set_all(5, 0); send(1'b1, 1'b0);
        set_all(1, 1); send(1'b0, 1'b0);
        set_all(2, 0); send(1'b0, 1'b1);
        check("toggle_result", dat_w16, {8{16'h0009}});
        idle(1);

        // Reset mid-frame
        set_all(7, 7); send(1'b1, 1'b0);
        in_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 128'(ov_w16), 128'(0));
        check("midrst_out_data",  dat_w16, 128'(0));
        check("midrst_in_ready",  128'(rdy_w16), 128'(1));
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        set_all(1, 0); send(1'b1, 1'b0);
        send(1'b1, 1'b1);
        check("post_rst_acc", dat_w16, {8{16'h0002}});
        idle(1);

        // W=8 wrap inside an accumulate frame
        set_all(16'h0080, 0);
        send(1'b1, 1'b0);
        send(1'b1, 1'b1);
        check("w8_wrap_data", 128'(dat_w8), 128'(0));
        check("w8_wrap_ovf",  128'(flg_w8), 128'(8'hFF));
        check("w16_no_wrap",  dat_w16, {8{16'h0100}});
        idle(1);

        // Boundary: exact max (no ovf) and double max, single-beat acc frame
        set_all(0, 0);
        cur_a[0] = 16'hFFFE; cur_b[0] = 16'h0001;
        cur_a[1] = 16'hFFFF; cur_b[1] = 16'hFFFF;
        send(1'b1, 1'b1);
        check("edge_w16_lane0", 128'(dat_w16[15:0]),  128'(16'hFFFF));
        check("edge_w16_lane1", 128'(dat_w16[31:16]), 128'(16'hFFFE));
        check("edge_s16_lane1", 128'(dat_s16[31:16]), 128'(16'hFFFF));
        check("edge_ovf",       128'(flg_s16), 128'(8'h02));
        idle(1);

        // Mixed stream with random downstream readiness
        done = 1'b0;
        fork
            begin
                for (int k = 0; k < 16; k++) begin
                    for (int l = 0; l < 8; l++) begin
                        cur_a[l] = int'($urandom_range(0, 65535));
                        cur_b[l] = int'($urandom_range(0, 65535));
                    end
                    send(k[1], (k % 3 == 2) || (k == 15));
                end
                in_valid = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 1) == 1);
                end
                out_ready = 1'b1;
            end
        join

        g = 0;
        while (q.size() != 0 && g < 20) begin
            @(posedge clk); #1;
            g++;
        end
        check("drain_empty", 128'(q.size()), 128'(0));
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
